// File: rtl/tft_frame_scheduler.sv
// TFT bus owner after panel init: sends the CASET/PASET/RAMWR window itself, then
// hands the byte bus to the scene painter or the 32x32 tile painter.
module tft_frame_scheduler #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 480,
  parameter int TILE_SZ  = 32,
  parameter int TILES_X  = 10,
  parameter int TILES_Y  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       redraw_req,
  input  logic       tile_req,
  input  logic [3:0] tile_x,
  input  logic [3:0] tile_y,
  output logic       tile_ack,
  output logic       tile_err,
  input  logic       tft_busy,
  input  logic       scene_dc,
  input  logic [7:0] scene_data,
  input  logic       scene_transmit,
  input  logic       scene_busy,
  output logic       scene_rst,
  output logic       scene_enable,
  input  logic       tile_dc,
  input  logic [7:0] tile_data,
  input  logic       tile_transmit,
  input  logic       tile_busy,
  output logic       tile_enable,
  output logic       tft_dc,
  output logic [7:0] tft_data,
  output logic       tft_transmit,
  output logic       frame_busy
);

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    IDLE      = 3'd1,
    CMD       = 3'd2,
    LOAD      = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [3:0]  TX_LIM  = 4'(TILES_X);
  localparam logic [3:0]  TY_LIM  = 4'(TILES_Y);
  localparam logic [15:0] TILE_W  = 16'(TILE_SZ);
  localparam logic [15:0] FULL_XE = 16'(SCREEN_W - 1);
  localparam logic [15:0] FULL_YE = 16'(SCREEN_H - 1);
  localparam logic [3:0]  CMD_LEN = 4'd11;

  state_t      state_r, state_n;
  logic        redraw_pend_r, slot_full_r, grant_tile_r, run_seen_r;
  logic [3:0]  slot_x_r, slot_y_r, idx_r;
  logic [15:0] xs_r, xe_r, ys_r, ye_r;
  logic        dc_r, transmit_r, scene_rst_r, scene_enable_r, tile_enable_r;
  logic        tile_ack_r, tile_err_r;
  logic [7:0]  data_r;
  logic        issue_s, done_s, grant_full_s, grant_tile_s, accept_s, gbusy_s;
  logic [8:0]  cmd_byte_s;

  // {dc, byte} for each position of the address-window command set
  function automatic logic [8:0] cmd_byte(input logic [3:0] i, input logic [15:0] xs,
                                          input logic [15:0] xe, input logic [15:0] ys,
                                          input logic [15:0] ye);
    case (i)
      4'd0:    cmd_byte = {1'b0, 8'h2A};
      4'd1:    cmd_byte = {1'b1, xs[15:8]};
      4'd2:    cmd_byte = {1'b1, xs[7:0]};
      4'd3:    cmd_byte = {1'b1, xe[15:8]};
      4'd4:    cmd_byte = {1'b1, xe[7:0]};
      4'd5:    cmd_byte = {1'b0, 8'h2B};
      4'd6:    cmd_byte = {1'b1, ys[15:8]};
      4'd7:    cmd_byte = {1'b1, ys[7:0]};
      4'd8:    cmd_byte = {1'b1, ye[15:8]};
      4'd9:    cmd_byte = {1'b1, ye[7:0]};
      4'd10:   cmd_byte = {1'b0, 8'h2C};
      default: cmd_byte = {1'b0, 8'h00};
    endcase
  endfunction

  assign gbusy_s    = grant_tile_r ? tile_busy : scene_busy;
  assign cmd_byte_s = cmd_byte(idx_r, xs_r, xe_r, ys_r, ye_r);
  assign accept_s   = tile_req && (state_r != WAIT_INIT) && !slot_full_r &&
                      (tile_x < TX_LIM) && (tile_y < TY_LIM);

  // Next-state and per-cycle control strobes
  always_comb begin
    state_n      = state_r;
    issue_s      = 1'b0;
    done_s       = 1'b0;
    grant_full_s = 1'b0;
    grant_tile_s = 1'b0;
    case (state_r)
      WAIT_INIT: begin
        if (init_done) state_n = IDLE;
        else           state_n = WAIT_INIT;
      end
      IDLE: begin
        if (redraw_pend_r) begin
          grant_full_s = 1'b1;
          state_n      = CMD;
        end else if (slot_full_r) begin
          grant_tile_s = 1'b1;
          state_n      = CMD;
        end else begin
          state_n = IDLE;
        end
      end
      CMD: begin
        // the last byte's strobe still belongs to CMD; LOAD follows it
        if (transmit_r) begin
          if (idx_r == CMD_LEN) state_n = LOAD;
          else                  state_n = CMD;
        end else if (!tft_busy && (idx_r < CMD_LEN)) begin
          issue_s = 1'b1;
        end else begin
          state_n = CMD;
        end
      end
      LOAD: state_n = RUN;
      RUN: begin
        if (run_seen_r && !gbusy_s) begin
          done_s  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = RUN;
        end
      end
      default: state_n = WAIT_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= WAIT_INIT;
    else        state_r <= state_n;
  end

  // Requests, tile slot, window latch and registered bus/control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redraw_pend_r  <= 1'b0;
      slot_full_r    <= 1'b0;
      slot_x_r       <= 4'd0;
      slot_y_r       <= 4'd0;
      grant_tile_r   <= 1'b0;
      run_seen_r     <= 1'b0;
      idx_r          <= 4'd0;
      xs_r           <= 16'd0;
      xe_r           <= 16'd0;
      ys_r           <= 16'd0;
      ye_r           <= 16'd0;
      dc_r           <= 1'b0;
      data_r         <= 8'd0;
      transmit_r     <= 1'b0;
      scene_rst_r    <= 1'b0;
      scene_enable_r <= 1'b0;
      tile_enable_r  <= 1'b0;
      tile_ack_r     <= 1'b0;
      tile_err_r     <= 1'b0;
    end else begin
      tile_ack_r <= accept_s;
      tile_err_r <= tile_req && !accept_s;
      if (accept_s) begin
        slot_full_r <= 1'b1;
        slot_x_r    <= tile_x;
        slot_y_r    <= tile_y;
      end else if (done_s && grant_tile_r) begin
        slot_full_r <= 1'b0;
      end

      // a pulse coinciding with the grant survives and earns another repaint
      if (redraw_req || ((state_r == WAIT_INIT) && init_done)) redraw_pend_r <= 1'b1;
      else if (grant_full_s)                                   redraw_pend_r <= 1'b0;

      if (grant_full_s) begin
        grant_tile_r <= 1'b0;
        idx_r        <= 4'd0;
        xs_r         <= 16'd0;
        xe_r         <= FULL_XE;
        ys_r         <= 16'd0;
        ye_r         <= FULL_YE;
      end else if (grant_tile_s) begin
        grant_tile_r <= 1'b1;
        idx_r        <= 4'd0;
        xs_r         <= 16'(slot_x_r) * TILE_W;
        xe_r         <= 16'(slot_x_r) * TILE_W + (TILE_W - 16'd1);
        ys_r         <= 16'(slot_y_r) * TILE_W;
        ye_r         <= 16'(slot_y_r) * TILE_W + (TILE_W - 16'd1);
      end else if (issue_s) begin
        idx_r <= idx_r + 4'd1;
      end

      transmit_r <= issue_s;
      if (issue_s) begin
        dc_r   <= cmd_byte_s[8];
        data_r <= cmd_byte_s[7:0];
      end

      run_seen_r     <= (state_r == RUN);
      scene_rst_r    <= (state_n == LOAD) && !grant_tile_r;
      scene_enable_r <= (state_n == RUN) && !grant_tile_r;
      tile_enable_r  <= (state_n == RUN) && grant_tile_r;
    end
  end

  assign tft_dc       = (state_r == RUN) ? (grant_tile_r ? tile_dc : scene_dc) : dc_r;
  assign tft_data     = (state_r == RUN) ? (grant_tile_r ? tile_data : scene_data) : data_r;
  assign tft_transmit = (state_r == RUN) ? (grant_tile_r ? tile_transmit : scene_transmit)
                                         : transmit_r;
  assign frame_busy   = (state_r == CMD) || (state_r == LOAD) || (state_r == RUN);
  assign scene_rst    = scene_rst_r;
  assign scene_enable = scene_enable_r;
  assign tile_enable  = tile_enable_r;
  assign tile_ack     = tile_ack_r;
  assign tile_err     = tile_err_r;

endmodule
